// File: rtl/rr_sch_bank.sv
// rtl/rr_sch_bank.sv - bank of independent round-robin arbiters with burst hold.
// Optional grant statistics are built when RR_SCH_BANK_STAT_EN is defined.
module rr_sch_bank #(
  parameter int NUM_ARB      = 16,
  parameter int NUM_PORT     = 4,
  parameter int LOG_NUM_PORT = 2,
  parameter int MAX_BURST    = 1,
  parameter int BURST_W      = 4,
  parameter int STAT_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic [NUM_ARB*NUM_PORT-1:0]     req,
  input  logic [NUM_ARB-1:0]              stall,
  output logic [NUM_ARB*NUM_PORT-1:0]     grant,
  output logic [NUM_ARB-1:0]              grant_vld,
  output logic [NUM_ARB*LOG_NUM_PORT-1:0] grant_idx,
  output logic [NUM_ARB*STAT_W-1:0]       stat_cnt
);

  for (genvar a = 0; a < NUM_ARB; a++) begin : g_arb
    logic [NUM_PORT-1:0]     g;
    logic [NUM_PORT-1:0]     r;
    logic [LOG_NUM_PORT-1:0] ptr;
    logic [LOG_NUM_PORT-1:0] idx;
    logic [LOG_NUM_PORT-1:0] win_idx;
    logic [BURST_W-1:0]      cnt;
    logic                    win;
    logic                    hold;
    int                      d;
    int                      best;

    assign r = req[a*NUM_PORT +: NUM_PORT];

    always_comb begin
      idx = '0;
      for (int p = 0; p < NUM_PORT; p++) begin
        if (g[p]) idx = LOG_NUM_PORT'(p);
      end
    end

    // Winner is the requester with the smallest modular distance from ptr.
    always_comb begin
      win     = 1'b0;
      win_idx = '0;
      best    = NUM_PORT;
      d       = 0;
      for (int p = 0; p < NUM_PORT; p++) begin
        d = (p >= int'(ptr)) ? (p - int'(ptr)) : (p + NUM_PORT - int'(ptr));
        if (r[p] && (d < best)) begin
          best    = d;
          win     = 1'b1;
          win_idx = LOG_NUM_PORT'(p);
        end
      end
    end

    assign hold = (|(g & r)) && (int'(cnt) < MAX_BURST - 1);

    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        g   <= '0;
        ptr <= '0;
        cnt <= '0;
      end else if (!stall[a]) begin
        if (hold) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          g   <= win ? (NUM_PORT'(1) << win_idx) : '0;
          if (win) begin
            ptr <= (win_idx == LOG_NUM_PORT'(NUM_PORT - 1)) ? '0 : win_idx + 1'b1;
          end
        end
      end
    end

`ifdef RR_SCH_BANK_STAT_EN
    logic [STAT_W-1:0] stat;

    // Counts only fresh wins; clr does not reset the statistics.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stat <= '0;
      end else if (!clr && !stall[a] && !hold && win && (stat != {STAT_W{1'b1}})) begin
        stat <= stat + 1'b1;
      end
    end

    assign stat_cnt[a*STAT_W +: STAT_W] = stat;
`else
    assign stat_cnt[a*STAT_W +: STAT_W] = '0;
`endif

    assign grant[a*NUM_PORT +: NUM_PORT]             = g;
    assign grant_vld[a]                              = |g;
    assign grant_idx[a*LOG_NUM_PORT +: LOG_NUM_PORT] = idx;
  end

endmodule

// File: tb/tb_rr_sch_bank.sv
// tb/tb_rr_sch_bank.sv - self-checking bench for rr_sch_bank in three configurations.
module tb_rr_sch_bank;

`ifdef RR_SCH_BANK_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr_a, clr_b, clr_c;
  logic [15:0] req_a;
  logic [3:0]  stall_a;
  logic [15:0] grant_a;
  logic [3:0]  vld_a;
  logic [7:0]  idx_a;
  logic [15:0] stat_a;
  logic [2:0]  req_b;
  logic        stall_b;
  logic [2:0]  grant_b;
  logic        vld_b;
  logic [1:0]  idx_b;
  logic [15:0] stat_b;
  logic [7:0]  req_c;
  logic [1:0]  stall_c;
  logic [7:0]  grant_c;
  logic [1:0]  vld_c;
  logic [3:0]  idx_c;
  logic [15:0] stat_c;

  int n_tests = 0;
  int n_fail  = 0;
  bit live    = 1'b0;

  rr_sch_bank #(.NUM_ARB(4), .NUM_PORT(4), .LOG_NUM_PORT(2), .MAX_BURST(1), .BURST_W(4), .STAT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .req(req_a), .stall(stall_a),
    .grant(grant_a), .grant_vld(vld_a), .grant_idx(idx_a), .stat_cnt(stat_a));

  rr_sch_bank #(.NUM_ARB(1), .NUM_PORT(3), .LOG_NUM_PORT(2), .MAX_BURST(1), .BURST_W(4), .STAT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .req(req_b), .stall(stall_b),
    .grant(grant_b), .grant_vld(vld_b), .grant_idx(idx_b), .stat_cnt(stat_b));

  rr_sch_bank #(.NUM_ARB(2), .NUM_PORT(4), .LOG_NUM_PORT(2), .MAX_BURST(3), .BURST_W(2), .STAT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr_c), .req(req_c), .stall(stall_c),
    .grant(grant_c), .grant_vld(vld_c), .grant_idx(idx_c), .stat_cnt(stat_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: who holds the grant, where the search starts, how long it has been held.
  typedef struct {
    int holder;
    int ptr;
    int run;
    int stat;
  } st_t;

  st_t ma[4];
  st_t mb[1];
  st_t mc[2];

  function automatic st_t step(st_t s, int r, bit stl, bit rst, bit cl, int n, int mburst, int smax);
    st_t o = s;
    if (rst) begin
      o.holder = -1; o.ptr = 0; o.run = 0; o.stat = 0;
    end else if (cl) begin
      o.holder = -1; o.ptr = 0; o.run = 0;
    end else if (!stl) begin
      if (s.holder >= 0 && ((r >> s.holder) & 1) == 1 && s.run < mburst) begin
        o.run = s.run + 1;
      end else begin
        o.holder = -1;
        o.run    = 0;
        for (int k = 0; k < n; k++) begin
          int p;
          p = (s.ptr + k) % n;
          if (o.holder < 0 && ((r >> p) & 1) == 1) begin
            o.holder = p;
            o.run    = 1;
            o.ptr    = (p + 1) % n;
            if (o.stat < smax) o.stat = o.stat + 1;
          end
        end
      end
    end
    return o;
  endfunction

  function automatic int exp_grant(st_t s);
    return (s.holder < 0) ? 0 : (1 << s.holder);
  endfunction

  function automatic int exp_idx(st_t s);
    return (s.holder < 0) ? 0 : s.holder;
  endfunction

  function automatic int exp_stat(st_t s);
    return STAT_ON ? s.stat : 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int a = 0; a < 4; a++)
      ma[a] = step(ma[a], int'(req_a[a*4 +: 4]), stall_a[a], !rst_n, clr_a, 4, 1, 15);
    mb[0] = step(mb[0], int'(req_b), stall_b, !rst_n, clr_b, 3, 1, 65535);
    for (int a = 0; a < 2; a++)
      mc[a] = step(mc[a], int'(req_c[a*4 +: 4]), stall_c[a], !rst_n, clr_c, 4, 3, 255);
  end

  always @(negedge clk) begin
    if (live) begin
      for (int a = 0; a < 4; a++) begin
        chk($sformatf("a%0d grant", a), int'(grant_a[a*4 +: 4]), exp_grant(ma[a]));
        chk($sformatf("a%0d idx", a),   int'(idx_a[a*2 +: 2]),   exp_idx(ma[a]));
        chk($sformatf("a%0d vld", a),   int'(vld_a[a]),          int'(ma[a].holder >= 0));
        chk($sformatf("a%0d stat", a),  int'(stat_a[a*4 +: 4]),  exp_stat(ma[a]));
      end
      chk("b grant", int'(grant_b), exp_grant(mb[0]));
      chk("b idx",   int'(idx_b),   exp_idx(mb[0]));
      chk("b vld",   int'(vld_b),   int'(mb[0].holder >= 0));
      chk("b stat",  int'(stat_b),  exp_stat(mb[0]));
      for (int a = 0; a < 2; a++) begin
        chk($sformatf("c%0d grant", a), int'(grant_c[a*4 +: 4]), exp_grant(mc[a]));
        chk($sformatf("c%0d idx", a),   int'(idx_c[a*2 +: 2]),   exp_idx(mc[a]));
        chk($sformatf("c%0d vld", a),   int'(vld_c[a]),          int'(mc[a].holder >= 0));
        chk($sformatf("c%0d stat", a),  int'(stat_c[a*8 +: 8]),  exp_stat(mc[a]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  int rot[8] = '{1, 2, 4, 8, 1, 2, 4, 8};

  initial begin
    rst_n = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    req_a = 16'hFFFF; stall_a = '0;
    req_b = 3'b101;   stall_b = 1'b0;
    req_c = 8'h03;    stall_c = '0;

    // Reset for two edges, grant must read zero.
    cyc(); live = 1'b1;
    chk("reset grant_a", int'(grant_a), 0);
    cyc();
    chk("reset grant_a 2", int'(grant_a), 0);
    chk("reset stat_a", int'(stat_a), 0);
    rst_n = 1'b1;

    cyc();
    chk("rel1 a0 grant", int'(grant_a[3:0]), 1);
    chk("rel1 a0 idx", int'(idx_a[1:0]), 0);
    chk("rel1 b grant", int'(grant_b), 1);
    chk("rel1 c0 grant", int'(grant_c[3:0]), 1);
    cyc();
    chk("rel2 a0 grant", int'(grant_a[3:0]), 2);
    chk("rel2 b grant", int'(grant_b), 4);
    chk("rel2 b idx", int'(idx_b), 2);
    chk("rel2 c0 grant", int'(grant_c[3:0]), 1);
    clr_a = 1'b1;
    cyc();
    chk("clr a grant", int'(grant_a), 0);
    chk("rel3 b grant", int'(grant_b), 1);
    chk("rel3 c0 grant", int'(grant_c[3:0]), 1);
    clr_a = 1'b0;
    cyc();
    chk("post clr a0 grant", int'(grant_a[3:0]), 1);
    chk("burst c0 grant 4", int'(grant_c[3:0]), 2);
    cyc();
    chk("burst c0 grant 5", int'(grant_c[3:0]), 2);
    cyc();
    chk("burst c0 grant 6", int'(grant_c[3:0]), 2);
    chk("burst c0 stat", int'(stat_c[7:0]), STAT_ON ? 2 : 0);
    cyc();
    chk("burst c0 grant 7", int'(grant_c[3:0]), 1);
    req_c = 8'h02;
    cyc();
    chk("drop c0 grant", int'(grant_c[3:0]), 2);

    // Rotation on arbiter 3 only.
    clr_a = 1'b1; req_a = 16'hF000;
    cyc();
    clr_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rot a3 %0d", i), int'(grant_a[15:12]), rot[i]);
      chk($sformatf("rot a0-2 %0d", i), int'(grant_a[11:0]), 0);
    end

    // Stall on arbiter 1 keeps a grant whose request has gone away.
    req_a = 16'h0040;
    cyc();
    chk("stall pre a1", int'(grant_a[7:4]), 4);
    stall_a = 4'b0010; req_a = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("stall a1 %0d", i), int'(grant_a[7:4]), 4);
    end
    stall_a = 4'b0000; req_a = 16'h0090;
    cyc();
    chk("stall release a1", int'(grant_a[7:4]), 8);
    stall_a = 4'b0010; clr_a = 1'b1;
    cyc();
    chk("clr in stall a1", int'(grant_a[7:4]), 0);
    clr_a = 1'b0; stall_a = 4'b0000;

    // Twenty fresh grants saturate a 4-bit counter.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req_a = 16'h000F;
    repeat (20) cyc();
    chk("stat sat a0", int'(stat_a[3:0]), STAT_ON ? 15 : 0);

    // Mixed traffic checked against the model only.
    for (int i = 0; i < 80; i++) begin
      req_a   = 16'($urandom);
      stall_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      clr_a   = ($urandom_range(0, 25) == 0);
      req_b   = 3'($urandom);
      stall_b = ($urandom_range(0, 4) == 0);
      req_c   = 8'($urandom);
      stall_c = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'h0;
      clr_c   = ($urandom_range(0, 30) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
